// File: rtl/dphy_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_rx_pkg
//  Description : Shared types and constants for the D-PHY HS receive path:
//                sequencer state encoding, default leader byte, counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dphy_rx_pkg;

    // Width of the settle and leader-timeout down-counters
    localparam int CNT_W = 8;

    // HS leader sequence byte as seen on the deserializer output
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_SYNC      = 3'd2,
        ST_DATA      = 3'd3,
        ST_WAIT_STOP = 3'd4
    } hs_state_t;

    // True when exactly one bit of v is set
    function automatic logic is_one_hot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_sync_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hs_sync_detect
//  Description : Combinational leader comparator. Flags an exact match of the
//                received byte against the leader byte, and separately a
//                byte that differs from it in exactly one bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_sync_detect
    import dphy_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic [7:0] byte_in,
    output logic       exact_match,
    output logic       single_err
);

    logic [7:0] diff;

    assign diff        = byte_in ^ SYNC_BYTE;
    assign exact_match = (diff == 8'h00);
    assign single_err  = is_one_hot8(diff);

endmodule
`default_nettype wire

// File: rtl/hs_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hs_rx_sequencer
//  Description : HS receive sequencer. On HS entry it enables the
//                deserializer, waits out the settle window, hunts for the
//                leader byte within a timeout, then streams payload bytes
//                until LP-11 returns. All outputs are registered.
//                Build option HS_SOT_ERR_TOLERANCE_EN: accept a leader byte
//                with a single-bit error and flag it on ErrSotHS.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_rx_sequencer
    import dphy_rx_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 6,
    parameter int         SYNC_TIMEOUT  = 16,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
    input  logic       RxByteClkHS,
    input  logic       RxRst_n,
    input  logic       hs_request,
    input  logic       lp_stop,
    input  logic [7:0] byte_in,
    output logic       deserializer_en,
    output logic       RxActiveHS,
    output logic       RxSyncHS,
    output logic       RxValidHS,
    output logic [7:0] RxDataHS,
    output logic       ErrSotHS,
    output logic       ErrSotSyncHS
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SYNC_TIMEOUT - 1);

    hs_state_t        state, state_n;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_n;
    logic [CNT_W-1:0] tout_cnt, tout_cnt_n;
    logic             des_en_n, active_n, sync_n, valid_n, err_sot_n, err_sync_n;
    logic [7:0]       data_n;
    logic             exact_match, single_err, tol_match;

    hs_sync_detect #(
        .SYNC_BYTE   (SYNC_BYTE)
    ) u_sync_detect (
        .byte_in     (byte_in),
        .exact_match (exact_match),
        .single_err  (single_err)
    );

    // Next state, counter and registered-output values; lp_stop wins over
    // leader match and timeout in every active state.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        tout_cnt_n   = tout_cnt;
        des_en_n     = 1'b0;
        active_n     = 1'b0;
        sync_n       = 1'b0;
        valid_n      = 1'b0;
        err_sot_n    = 1'b0;
        err_sync_n   = 1'b0;
        data_n       = RxDataHS;
        case (state)
            ST_IDLE: begin
                if (hs_request && !lp_stop) begin
                    state_n      = ST_SETTLE;
                    settle_cnt_n = SETTLE_LOAD;
                    des_en_n     = 1'b1;
                    active_n     = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (lp_stop) begin
                    state_n = ST_IDLE;
                end else begin
                    des_en_n = 1'b1;
                    active_n = 1'b1;
                    if (settle_cnt == '0) begin
                        state_n    = ST_SYNC;
                        tout_cnt_n = TIMEOUT_LOAD;
                    end else begin
                        settle_cnt_n = settle_cnt - 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (lp_stop) begin
                    state_n = ST_IDLE;
                end else if (exact_match || tol_match) begin
                    state_n   = ST_DATA;
                    des_en_n  = 1'b1;
                    active_n  = 1'b1;
                    sync_n    = 1'b1;
                    err_sot_n = !exact_match;
                end else if (tout_cnt == '0) begin
                    state_n    = ST_WAIT_STOP;
                    err_sync_n = 1'b1;
                end else begin
                    tout_cnt_n = tout_cnt - 1'b1;
                    des_en_n   = 1'b1;
                    active_n   = 1'b1;
                end
            end
            ST_DATA: begin
                if (lp_stop) begin
                    state_n = ST_IDLE;
                end else begin
                    des_en_n = 1'b1;
                    active_n = 1'b1;
                    valid_n  = 1'b1;
                    data_n   = byte_in;
                end
            end
            ST_WAIT_STOP: begin
                if (lp_stop) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and outputs; reset discards any burst silently.
    always_ff @(posedge RxByteClkHS or negedge RxRst_n) begin
        if (!RxRst_n) begin
            state           <= ST_IDLE;
            settle_cnt      <= '0;
            tout_cnt        <= '0;
            deserializer_en <= 1'b0;
            RxActiveHS      <= 1'b0;
            RxSyncHS        <= 1'b0;
            RxValidHS       <= 1'b0;
            RxDataHS        <= 8'h00;
            ErrSotSyncHS    <= 1'b0;
        end else begin
            state           <= state_n;
            settle_cnt      <= settle_cnt_n;
            tout_cnt        <= tout_cnt_n;
            deserializer_en <= des_en_n;
            RxActiveHS      <= active_n;
            RxSyncHS        <= sync_n;
            RxValidHS       <= valid_n;
            RxDataHS        <= data_n;
            ErrSotSyncHS    <= err_sync_n;
        end
    end

`ifdef HS_SOT_ERR_TOLERANCE_EN
    assign tol_match = single_err;

    logic err_sot_q;

    // Single-bit-error leader flag, pulsed alongside RxSyncHS.
    always_ff @(posedge RxByteClkHS or negedge RxRst_n) begin
        if (!RxRst_n) begin
            err_sot_q <= 1'b0;
        end else begin
            err_sot_q <= err_sot_n;
        end
    end

    assign ErrSotHS = err_sot_q;
`else
    assign tol_match = 1'b0;
    assign ErrSotHS  = 1'b0;

    logic unused_tolerance;
    assign unused_tolerance = single_err ^ err_sot_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hs_rx_sequencer
//  Description : Directed self-checking bench for hs_rx_sequencer with the
//                default parameters (settle 6, timeout 16, leader B8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_rx_sequencer;

    logic       clk;
    logic       rst_n;
    logic       hs_request;
    logic       lp_stop;
    logic [7:0] byte_in;
    logic       deserializer_en;
    logic       RxActiveHS;
    logic       RxSyncHS;
    logic       RxValidHS;
    logic [7:0] RxDataHS;
    logic       ErrSotHS;
    logic       ErrSotSyncHS;

    int tests_run    = 0;
    int tests_failed = 0;

    hs_rx_sequencer #(
        .SETTLE_CYCLES (6),
        .SYNC_TIMEOUT  (16),
        .SYNC_BYTE     (8'hB8)
    ) dut (
        .RxByteClkHS     (clk),
        .RxRst_n         (rst_n),
        .hs_request      (hs_request),
        .lp_stop         (lp_stop),
        .byte_in         (byte_in),
        .deserializer_en (deserializer_en),
        .RxActiveHS      (RxActiveHS),
        .RxSyncHS        (RxSyncHS),
        .RxValidHS       (RxValidHS),
        .RxDataHS        (RxDataHS),
        .ErrSotHS        (ErrSotHS),
        .ErrSotSyncHS    (ErrSotSyncHS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed flags packed as {en, active, sync, valid, err_sot, err_sync}
    function automatic logic [5:0] flags();
        return {deserializer_en, RxActiveHS, RxSyncHS, RxValidHS, ErrSotHS, ErrSotSyncHS};
    endfunction

    // Drive one byte-clock worth of inputs, then sample 1 time unit after the edge
    task automatic step(input logic req, input logic stop, input logic [7:0] b);
        hs_request = req;
        lp_stop    = stop;
        byte_in    = b;
        @(posedge clk);
        #1;
    endtask

    // Request HS and run through the settle window; leaves the FSM in SYNC
    task automatic enter_sync();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; hs_request = 1'b0; lp_stop = 1'b0; byte_in = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (flags() !== 6'b000000 || RxDataHS !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_values: flags=%b data=%h, required flags=000000 data=00", flags(), RxDataHS);
        end
        #10 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_idle_hold: flags=%b, required 000000", flags());
        end
    endtask

    task automatic test_basic_burst();
        step(1'b1, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b110000) begin
            tests_failed++;
            $display("FAIL burst_settle_entry: flags=%b, required 110000", flags());
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b110000) begin
            tests_failed++;
            $display("FAIL burst_settle_end: flags=%b, required 110000", flags());
        end
        step(1'b0, 1'b0, 8'hB8);
        tests_run++;
        if (flags() !== 6'b111000 || RxDataHS !== 8'h00) begin
            tests_failed++;
            $display("FAIL burst_sync: flags=%b data=%h, required flags=111000 data=00", flags(), RxDataHS);
        end
        step(1'b0, 1'b0, 8'h11);
        tests_run++;
        if (flags() !== 6'b110100 || RxDataHS !== 8'h11) begin
            tests_failed++;
            $display("FAIL burst_data0: flags=%b data=%h, required flags=110100 data=11", flags(), RxDataHS);
        end
        step(1'b0, 1'b0, 8'h22);
        tests_run++;
        if (flags() !== 6'b110100 || RxDataHS !== 8'h22) begin
            tests_failed++;
            $display("FAIL burst_data1: flags=%b data=%h, required flags=110100 data=22", flags(), RxDataHS);
        end
        step(1'b0, 1'b1, 8'h33);
        tests_run++;
        if (flags() !== 6'b000000 || RxDataHS !== 8'h22) begin
            tests_failed++;
            $display("FAIL burst_stop: flags=%b data=%h, required flags=000000 data=22", flags(), RxDataHS);
        end
        step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL burst_idle_after: flags=%b, required 000000", flags());
        end
    endtask

    task automatic test_timeout();
        enter_sync();
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 8'h00);
            tests_run++;
            if (flags() !== 6'b110000) begin
                tests_failed++;
                $display("FAIL timeout_hunt[%0d]: flags=%b, required 110000", i, flags());
            end
        end
        step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b000001) begin
            tests_failed++;
            $display("FAIL timeout_pulse: flags=%b, required 000001", flags());
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'hB8);
            tests_run++;
            if (flags() !== 6'b000000) begin
                tests_failed++;
                $display("FAIL timeout_wait_stop[%0d]: flags=%b, required 000000", i, flags());
            end
        end
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b110000) begin
            tests_failed++;
            $display("FAIL timeout_back_to_idle: flags=%b, required 110000", flags());
        end
        step(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL settle_abort: flags=%b, required 000000", flags());
        end
    endtask

    task automatic test_single_bit();
        enter_sync();
        step(1'b0, 1'b0, 8'hB9);
`ifdef HS_SOT_ERR_TOLERANCE_EN
        tests_run++;
        if (flags() !== 6'b111010) begin
            tests_failed++;
            $display("FAIL onebit_accept: flags=%b, required 111010", flags());
        end
        step(1'b0, 1'b0, 8'h5A);
        tests_run++;
        if (flags() !== 6'b110100 || RxDataHS !== 8'h5A) begin
            tests_failed++;
            $display("FAIL onebit_data: flags=%b data=%h, required flags=110100 data=5A", flags(), RxDataHS);
        end
`else
        tests_run++;
        if (flags() !== 6'b110000) begin
            tests_failed++;
            $display("FAIL onebit_reject: flags=%b, required 110000", flags());
        end
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b000001) begin
            tests_failed++;
            $display("FAIL onebit_timeout: flags=%b, required 000001", flags());
        end
`endif
        step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_stop_priority();
        enter_sync();
        step(1'b0, 1'b1, 8'hB8);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL stop_vs_match: flags=%b, required 000000", flags());
        end
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL idle_req_and_stop: flags=%b, required 000000", flags());
        end
    endtask

    task automatic test_async_reset();
        enter_sync();
        step(1'b0, 1'b0, 8'hB8);
        step(1'b0, 1'b0, 8'hA5);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (flags() !== 6'b000000 || RxDataHS !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: flags=%b data=%h, required flags=000000 data=00", flags(), RxDataHS);
        end
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        enter_sync();
        step(1'b0, 1'b0, 8'hB8);
        tests_run++;
        if (flags() !== 6'b111000) begin
            tests_failed++;
            $display("FAIL post_reset_sync: flags=%b, required 111000", flags());
        end
        step(1'b0, 1'b0, 8'hC3);
        tests_run++;
        if (flags() !== 6'b110100 || RxDataHS !== 8'hC3) begin
            tests_failed++;
            $display("FAIL post_reset_data: flags=%b data=%h, required flags=110100 data=C3", flags(), RxDataHS);
        end
        step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_req_toggle();
        logic [7:0] b;
        enter_sync();
        step(1'b0, 1'b0, 8'hB8);
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i * 17);
            step(i[0], 1'b0, b);
            tests_run++;
            if (flags() !== 6'b110100 || RxDataHS !== b) begin
                tests_failed++;
                $display("FAIL req_toggle[%0d]: flags=%b data=%h, required flags=110100 data=%h", i, flags(), RxDataHS, b);
            end
        end
        step(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (flags() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL req_toggle_stop: flags=%b, required 000000", flags());
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_timeout();
        test_single_bit();
        test_stop_priority();
        test_async_reset();
        test_req_toggle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
